mac_sequencer: RTL

Controller that sequences one `mac_unit` subcore. It arbitrates between a weight-load requester and an axon-MAC requester and drives `start_weight` / `start_mac` as exact DIMENSION-cycle windows. It manages the subcore power state through `sel` and `mem_sd`, and flags when `accum_out_reg` holds a fresh result. It sits between the core-level scheduler and `mac_unit`, one instance per subcore.

---
 rtl/mac_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// Sequencer for one mac_unit subcore: arbitrates weight-load vs MAC requests,
// generates exact DIMENSION-cycle start windows and manages subcore power state.
module mac_sequencer #(
  parameter int DIMENSION    = 128,
  parameter int ADDR_WIDTH   = 7,
  parameter int WAKE_CYCLES  = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  power_en,
  input  logic                  wt_req,
  input  logic                  mac_req,
  output logic                  wt_ack,
  output logic                  mac_ack,
  output logic                  start_weight,
  output logic                  start_mac,
  output logic [ADDR_WIDTH-1:0] row_idx,
  output logic                  sel,
  output logic                  mem_sd,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int CNT_MAX_A = (DIMENSION > WAKE_CYCLES) ? DIMENSION : WAKE_CYCLES;
  localparam int CNT_MAX_B = (IDLE_TIMEOUT > DRAIN_CYCLES) ? IDLE_TIMEOUT : DRAIN_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(DIMENSION - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SLEEP = 3'd1,
    ST_IDLE  = 3'd2,
    ST_WAKE  = 3'd3,
    ST_LOAD  = 3'd4,
    ST_MAC   = 3'd5,
    ST_DRAIN = 3'd6,
    ST_GAP   = 3'd7
  } state_t;

  state_t                state_r, state_nxt_s, arb_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  sel_nxt_s, mem_sd_nxt_s, busy_nxt_s;
  logic                  sw_nxt_s, sm_nxt_s, wt_ack_nxt_s, mac_ack_nxt_s, rv_nxt_s;
  logic [ADDR_WIDTH-1:0] row_nxt_s;

  // Arbitration outcome used in every decision state; weights win ties.
  always_comb begin
    if (wt_req) begin
      arb_s = ST_LOAD;
    end else if (mac_req) begin
      arb_s = ST_MAC;
    end else begin
      arb_s = ST_IDLE;
    end
  end

  // Next-state and shared cycle counter (wake, window row, idle, drain).
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = '0;
    case (state_r)
      ST_OFF: begin
        if (power_en) state_nxt_s = ST_SLEEP;
        else          state_nxt_s = ST_OFF;
      end
      ST_SLEEP: begin
        if (!power_en)              state_nxt_s = ST_OFF;
        else if (wt_req || mac_req) state_nxt_s = ST_WAKE;
        else                        state_nxt_s = ST_SLEEP;
      end
      ST_WAKE: begin
        if (cnt_r == WAKE_LAST) begin
          state_nxt_s = arb_s;
        end else begin
          state_nxt_s = ST_WAKE;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (!power_en) begin
          state_nxt_s = ST_OFF;
        end else if (wt_req || mac_req) begin
          state_nxt_s = arb_s;
        end else if (cnt_r == IDLE_LAST) begin
          state_nxt_s = ST_SLEEP;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_LOAD: begin
        if (cnt_r == ROW_LAST) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_LOAD;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_MAC: begin
        if (cnt_r == ROW_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_MAC;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (!power_en) state_nxt_s = ST_OFF;
        else           state_nxt_s = arb_s;
      end
      default: begin
        state_nxt_s = ST_OFF;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r <= ST_OFF;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output decode from the upcoming state so every output can be registered.
  always_comb begin
    sel_nxt_s    = 1'b0;
    mem_sd_nxt_s = 1'b0;
    busy_nxt_s   = 1'b0;
    sw_nxt_s     = 1'b0;
    sm_nxt_s     = 1'b0;
    row_nxt_s    = '0;
    case (state_nxt_s)
      ST_OFF:   mem_sd_nxt_s = 1'b1;
      ST_SLEEP: mem_sd_nxt_s = 1'b0;
      ST_IDLE:  sel_nxt_s    = 1'b1;
      ST_WAKE, ST_DRAIN, ST_GAP: begin
        sel_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_LOAD: begin
        sel_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
        sw_nxt_s   = 1'b1;
        row_nxt_s  = ADDR_WIDTH'(cnt_nxt_s);
      end
      ST_MAC: begin
        sel_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
        sm_nxt_s   = 1'b1;
        row_nxt_s  = ADDR_WIDTH'(cnt_nxt_s);
      end
      default: mem_sd_nxt_s = 1'b1;
    endcase
  end

  assign wt_ack_nxt_s  = (state_nxt_s == ST_LOAD) && (state_r != ST_LOAD);
  assign mac_ack_nxt_s = (state_nxt_s == ST_MAC) && (state_r != ST_MAC);
  // The accumulator is only valid after a MAC drain, never after a load.
  assign rv_nxt_s      = (state_r == ST_DRAIN) && (state_nxt_s == ST_GAP);

  // Output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wt_ack       <= 1'b0;
      mac_ack      <= 1'b0;
      start_weight <= 1'b0;
      start_mac    <= 1'b0;
      row_idx      <= '0;
      sel          <= 1'b0;
      mem_sd       <= 1'b1;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wt_ack       <= wt_ack_nxt_s;
      mac_ack      <= mac_ack_nxt_s;
      start_weight <= sw_nxt_s;
      start_mac    <= sm_nxt_s;
      row_idx      <= row_nxt_s;
      sel          <= sel_nxt_s;
      mem_sd       <= mem_sd_nxt_s;
      result_valid <= rv_nxt_s;
      busy         <= busy_nxt_s;
    end
  end

endmodule
